// File: rtl/dps_req_arbiter_if.sv
// Bundle of the two master ports and the DPS request port around dps_req_arbiter.
// Signal names carry the direction as seen from the arbiter.
interface dps_req_arbiter_if;
    logic        iM0_REQ;
    logic        oM0_BUSY;
    logic        iM0_RW;
    logic [31:0] iM0_ADDR;
    logic [31:0] iM0_DATA;
    logic        oM0_VALID;
    logic [31:0] oM0_DATA;
    logic        oM0_ERR;

    logic        iM1_REQ;
    logic        oM1_BUSY;
    logic        iM1_RW;
    logic [31:0] iM1_ADDR;
    logic [31:0] iM1_DATA;
    logic        oM1_VALID;
    logic [31:0] oM1_DATA;
    logic        oM1_ERR;

    logic        oDPS_REQ;
    logic        iDPS_BUSY;
    logic        oDPS_RW;
    logic [31:0] oDPS_ADDR;
    logic [31:0] oDPS_DATA;
    logic        iDPS_VALID;
    logic [31:0] iDPS_DATA;

    // arbiter side
    modport slave (
        input  iM0_REQ, iM0_RW, iM0_ADDR, iM0_DATA,
        output oM0_BUSY, oM0_VALID, oM0_DATA, oM0_ERR,
        input  iM1_REQ, iM1_RW, iM1_ADDR, iM1_DATA,
        output oM1_BUSY, oM1_VALID, oM1_DATA, oM1_ERR,
        output oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA,
        input  iDPS_BUSY, iDPS_VALID, iDPS_DATA
    );

    // environment side (masters plus DPS)
    modport master (
        output iM0_REQ, iM0_RW, iM0_ADDR, iM0_DATA,
        input  oM0_BUSY, oM0_VALID, oM0_DATA, oM0_ERR,
        output iM1_REQ, iM1_RW, iM1_ADDR, iM1_DATA,
        input  oM1_BUSY, oM1_VALID, oM1_DATA, oM1_ERR,
        input  oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA,
        output iDPS_BUSY, iDPS_VALID, iDPS_DATA
    );
endinterface

// File: rtl/dps_req_arbiter.sv
// Round-robin two-master arbiter in front of the DPS request port. It tracks the single
// outstanding read, routes its response to the issuing master and forces an error on timeout.
module dps_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               iCLOCK,
    input  logic               inRESET,
    dps_req_arbiter_if.slave   bus
);
    localparam int NUM_M = 2;
    localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TMO_LAST = 16'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_owner;
    logic        r_prio;
    logic [15:0] r_cnt;

    logic [NUM_M-1:0]       w_req, w_rw;
    logic [NUM_M-1:0][31:0] w_addr, w_wdata;
    logic [NUM_M-1:0]       w_busy, w_valid, w_err;
    logic [NUM_M-1:0][31:0] w_rdata;

    logic        w_win, w_idle, w_fwd, w_acc, w_acc_rd;
    logic        w_tmo, w_rsp;
    logic [31:0] w_rsp_data;

    assign w_req   = {bus.iM1_REQ,  bus.iM0_REQ};
    assign w_rw    = {bus.iM1_RW,   bus.iM0_RW};
    assign w_addr  = {bus.iM1_ADDR, bus.iM0_ADDR};
    assign w_wdata = {bus.iM1_DATA, bus.iM0_DATA};

    // A lone requester wins outright; prio only breaks ties.
    always_comb begin
        w_win = r_prio;
        if (!w_req[1])      w_win = 1'b0;
        else if (!w_req[0]) w_win = 1'b1;
    end

    assign w_idle   = (r_state == IDLE);
    assign w_fwd    = w_idle && (|w_req);
    assign w_acc    = w_fwd && !bus.iDPS_BUSY;
    assign w_acc_rd = w_acc && !w_rw[w_win];

    assign bus.oDPS_REQ  = w_fwd;
    assign bus.oDPS_RW   = w_fwd ? w_rw[w_win]    : 1'b0;
    assign bus.oDPS_ADDR = w_fwd ? w_addr[w_win]  : 32'h0;
    assign bus.oDPS_DATA = w_fwd ? w_wdata[w_win] : 32'h0;

    // A real response in the expiry cycle takes precedence over the timeout error.
    assign w_tmo      = TMO_EN && (r_cnt == TMO_LAST);
    assign w_rsp      = (r_state == RD_WAIT) && (bus.iDPS_VALID || w_tmo);
    assign w_rsp_data = bus.iDPS_VALID ? bus.iDPS_DATA : 32'hFFFF_FFFF;

    for (genvar i = 0; i < NUM_M; i++) begin : g_mst
        assign w_busy[i]  = w_req[i] && !(w_acc && (w_win == 1'(i)));
        assign w_valid[i] = w_rsp && (r_owner == 1'(i));
        assign w_err[i]   = w_valid[i] && !bus.iDPS_VALID;
        assign w_rdata[i] = w_valid[i] ? w_rsp_data : 32'h0;
    end

    assign bus.oM0_BUSY  = w_busy[0];
    assign bus.oM0_VALID = w_valid[0];
    assign bus.oM0_DATA  = w_rdata[0];
    assign bus.oM0_ERR   = w_err[0];
    assign bus.oM1_BUSY  = w_busy[1];
    assign bus.oM1_VALID = w_valid[1];
    assign bus.oM1_DATA  = w_rdata[1];
    assign bus.oM1_ERR   = w_err[1];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_acc_rd) w_state_nxt = RD_WAIT;
            RD_WAIT: if (w_rsp)    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_prio  <= 1'b0;
            r_cnt   <= 16'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc)    r_prio  <= ~w_win;
            if (w_acc_rd) r_owner <= w_win;
            if (w_acc_rd)
                r_cnt <= 16'h0;
            else if ((r_state == RD_WAIT) && (r_cnt != 16'hFFFF))
                r_cnt <= r_cnt + 16'h1;
        end
    end
endmodule

// File: tb/tb_dps_req_arbiter.sv
// Directed bench for dps_req_arbiter: inputs change 1ns after posedge, outputs sampled at negedge.
module tb_dps_req_arbiter;
    logic iCLOCK = 1'b0;
    logic inRESET = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    dps_req_arbiter_if bus();

    dps_req_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .iCLOCK (iCLOCK),
        .inRESET(inRESET),
        .bus    (bus.slave)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic smp;
        @(negedge iCLOCK);
    endtask

    task automatic idle_in;
        bus.iM0_REQ = 0; bus.iM0_RW = 0; bus.iM0_ADDR = 0; bus.iM0_DATA = 0;
        bus.iM1_REQ = 0; bus.iM1_RW = 0; bus.iM1_ADDR = 0; bus.iM1_DATA = 0;
        bus.iDPS_BUSY = 0; bus.iDPS_VALID = 0; bus.iDPS_DATA = 0;
    endtask

    task automatic do_reset;
        inRESET = 0;
        smp();
        tick();
        inRESET = 1;
    endtask

    task automatic chk_no_rsp(input string tag);
        chk({tag, "_v0"}, 32'(bus.oM0_VALID), 0);
        chk({tag, "_v1"}, 32'(bus.oM1_VALID), 0);
        chk({tag, "_d0"}, bus.oM0_DATA, 0);
        chk({tag, "_d1"}, bus.oM1_DATA, 0);
    endtask

    initial begin
        idle_in();
        #1;
        // reset state
        smp();
        chk("rst_req",   32'(bus.oDPS_REQ), 0);
        chk("rst_busy0", 32'(bus.oM0_BUSY), 0);
        chk("rst_busy1", 32'(bus.oM1_BUSY), 0);
        chk("rst_addr",  bus.oDPS_ADDR, 0);
        chk("rst_err0",  32'(bus.oM0_ERR), 0);
        chk_no_rsp("rst");
        tick();
        inRESET = 1;

        // single M0 write, forwarded combinationally
        bus.iM0_REQ = 1; bus.iM0_RW = 1; bus.iM0_ADDR = 32'h100; bus.iM0_DATA = 32'h55;
        smp();
        chk("wr_req",   32'(bus.oDPS_REQ), 1);
        chk("wr_addr",  bus.oDPS_ADDR, 32'h100);
        chk("wr_data",  bus.oDPS_DATA, 32'h55);
        chk("wr_rw",    32'(bus.oDPS_RW), 1);
        chk("wr_busy0", 32'(bus.oM0_BUSY), 0);
        tick();

        // prio now favours M1; continuous writes from both alternate M1, M0, M1, M0
        bus.iM0_ADDR = 32'hA0; bus.iM1_REQ = 1; bus.iM1_RW = 1; bus.iM1_ADDR = 32'hB0; bus.iM1_DATA = 32'h66;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk($sformatf("alt%0d_addr", k), bus.oDPS_ADDR, (k % 2 == 0) ? 32'hB0 : 32'hA0);
            chk($sformatf("alt%0d_busy0", k), 32'(bus.oM0_BUSY), (k % 2 == 0) ? 1 : 0);
            chk($sformatf("alt%0d_busy1", k), 32'(bus.oM1_BUSY), (k % 2 == 0) ? 0 : 1);
            tick();
        end
        idle_in();
        do_reset();

        // both read after reset: M0 first, M1 held busy
        bus.iM0_REQ = 1; bus.iM0_ADDR = 32'h200;
        bus.iM1_REQ = 1; bus.iM1_ADDR = 32'h300;
        smp();
        chk("rr_addr0", bus.oDPS_ADDR, 32'h200);
        chk("rr_rw0",   32'(bus.oDPS_RW), 0);
        chk("rr_busy0", 32'(bus.oM0_BUSY), 0);
        chk("rr_busy1a", 32'(bus.oM1_BUSY), 1);
        tick();
        bus.iM0_REQ = 0;
        for (int k = 0; k < 2; k++) begin
            smp();
            chk("rr_wait_req", 32'(bus.oDPS_REQ), 0);
            chk("rr_wait_busy1", 32'(bus.oM1_BUSY), 1);
            chk_no_rsp("rr_wait");
            tick();
        end
        bus.iDPS_VALID = 1; bus.iDPS_DATA = 32'h11;
        smp();
        chk("rr_v0",    32'(bus.oM0_VALID), 1);
        chk("rr_d0",    bus.oM0_DATA, 32'h11);
        chk("rr_e0",    32'(bus.oM0_ERR), 0);
        chk("rr_v1x",   32'(bus.oM1_VALID), 0);
        chk("rr_busy1d", 32'(bus.oM1_BUSY), 1);
        tick();
        bus.iDPS_VALID = 0; bus.iDPS_DATA = 0;
        smp();
        chk("rr_m1_addr", bus.oDPS_ADDR, 32'h300);
        chk("rr_m1_busy", 32'(bus.oM1_BUSY), 0);
        chk("rr_pulse",   32'(bus.oM0_VALID), 0);
        tick();
        bus.iM1_REQ = 0;
        smp();
        tick();
        bus.iDPS_VALID = 1; bus.iDPS_DATA = 32'h22;
        smp();
        chk("rr_v1",  32'(bus.oM1_VALID), 1);
        chk("rr_d1",  bus.oM1_DATA, 32'h22);
        chk("rr_v0x", 32'(bus.oM0_VALID), 0);
        chk("rr_d0x", bus.oM0_DATA, 0);
        tick();
        bus.iDPS_VALID = 0; bus.iDPS_DATA = 0;
        smp();
        chk("rr_v1_pulse", 32'(bus.oM1_VALID), 0);
        tick();

        // DPS busy stalls acceptance
        bus.iDPS_BUSY = 1;
        bus.iM1_REQ = 1; bus.iM1_RW = 1; bus.iM1_ADDR = 32'hC0;
        for (int k = 0; k < 5; k++) begin
            smp();
            chk($sformatf("bz%0d_busy1", k), 32'(bus.oM1_BUSY), 1);
            chk($sformatf("bz%0d_req", k), 32'(bus.oDPS_REQ), 1);
            tick();
        end
        bus.iDPS_BUSY = 0;
        smp();
        chk("bz_acc_busy1", 32'(bus.oM1_BUSY), 0);
        tick();
        idle_in();

        // M1 read times out in the 8th wait cycle; late response dropped
        bus.iM1_REQ = 1; bus.iM1_ADDR = 32'h400;
        smp();
        chk("to_acc_busy1", 32'(bus.oM1_BUSY), 0);
        tick();
        bus.iM1_REQ = 0;
        for (int k = 1; k <= 7; k++) begin
            smp();
            chk($sformatf("to_w%0d_v1", k), 32'(bus.oM1_VALID), 0);
            tick();
        end
        smp();
        chk("to_v1",  32'(bus.oM1_VALID), 1);
        chk("to_e1",  32'(bus.oM1_ERR), 1);
        chk("to_d1",  bus.oM1_DATA, 32'hFFFF_FFFF);
        chk("to_v0x", 32'(bus.oM0_VALID), 0);
        tick();
        smp();
        tick();
        bus.iDPS_VALID = 1; bus.iDPS_DATA = 32'h77;
        smp();
        chk_no_rsp("late");
        chk("late_e1", 32'(bus.oM1_ERR), 0);
        tick();
        idle_in();

        // response coincident with timeout expiry wins
        bus.iM0_REQ = 1; bus.iM0_ADDR = 32'h500;
        smp();
        tick();
        bus.iM0_REQ = 0;
        for (int k = 1; k <= 7; k++) begin
            smp();
            tick();
        end
        bus.iDPS_VALID = 1; bus.iDPS_DATA = 32'h99;
        smp();
        chk("co_v0", 32'(bus.oM0_VALID), 1);
        chk("co_e0", 32'(bus.oM0_ERR), 0);
        chk("co_d0", bus.oM0_DATA, 32'h99);
        tick();
        idle_in();

        // reset during RD_WAIT; M0 read leaves prio favouring M1 until reset clears it
        bus.iM0_REQ = 1; bus.iM0_ADDR = 32'h600;
        smp();
        tick();
        bus.iM0_REQ = 0;
        smp();
        tick();
        inRESET = 0;
        smp();
        chk("mr_req", 32'(bus.oDPS_REQ), 0);
        chk_no_rsp("mr");
        tick();
        inRESET = 1;
        bus.iDPS_VALID = 1; bus.iDPS_DATA = 32'h33;
        smp();
        chk_no_rsp("mr_late");
        tick();
        bus.iDPS_VALID = 0; bus.iDPS_DATA = 0;
        bus.iM0_REQ = 1; bus.iM0_RW = 1; bus.iM0_ADDR = 32'hD0;
        bus.iM1_REQ = 1; bus.iM1_RW = 1; bus.iM1_ADDR = 32'hE0;
        smp();
        chk("mr_prio_addr",  bus.oDPS_ADDR, 32'hD0);
        chk("mr_prio_busy1", 32'(bus.oM1_BUSY), 1);
        tick();
        idle_in();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
